// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and defaults for the pulse stretcher
// Purpose: FSM state encoding, default phase lengths and a small helper
// used to size the phase counter. No ports.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // 10 ms high / 5 ms minimum gap at a 10 MHz clock
  localparam int HIGH_CYC_DEF = 100000;
  localparam int LOW_CYC_DEF  = 50000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-cycle rising-edge detector
// Purpose: flags the first cycle of each high level on d.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset (previous level forced low)
//   d     in  level to watch
//   rise  out high for the cycle where d=1 and the registered d was 0
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  // prev is cleared in reset so a level held through release counts once
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches event strobes into visible pulses
// Purpose: each rising edge of pulso yields one HIGH_CYC-long salida pulse
// followed by at least LOW_CYC cycles low; events arriving while a pulse
// is in progress are queued in a saturating counter.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   pulso   in  event strobe (one event per rising edge)
//   clr_ovf in  clears the overflow flag
//   salida  out stretched pulse, registered
//   busy    out high whenever the FSM is not IDLE, registered
//   pend    out queued events not yet started
//   ovf     out sticky: an event was dropped because pend was full
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYC = HIGH_CYC_DEF,
  parameter int LOW_CYC  = LOW_CYC_DEF,
  parameter int PEND_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulso,
  input  logic              clr_ovf,
  output logic              salida,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int CNT_W = $clog2(max_int(HIGH_CYC, LOW_CYC) + 1);

  localparam logic [CNT_W-1:0]  HIGH_LD  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0]  LOW_LD   = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ev;
  logic             start;
  logic             inc;
  logic             dec;
  logic             drop;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (pulso),
    .rise  (ev)
  );

  // A pulse starts from IDLE or from the last OFF cycle whenever there is
  // something to show. A new event at that moment is what gets consumed,
  // so only a start without a new event draws on the queue; both orders
  // of consumption give the same count.
  always_comb begin
    start = 1'b0;
    if ((ev || pend != '0) &&
        (state == IDLE || (state == OFF && cnt == '0)))
      start = 1'b1;
    inc  = ev && !start;
    dec  = start && !ev;
    drop = inc && (pend == PEND_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      salida <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ON;
            cnt    <= HIGH_LD;
            salida <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ON: begin
          if (cnt == '0) begin
            state  <= OFF;
            cnt    <= LOW_LD;
            salida <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        OFF: begin
          if (cnt == '0) begin
            if (start) begin
              state  <= ON;
              cnt    <= HIGH_LD;
              salida <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          salida <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // inc and dec are mutually exclusive by construction
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      if (inc && !drop) pend <= pend + PEND_ONE;
      else if (dec)     pend <= pend - PEND_ONE;

      // a drop in the same cycle outranks the clear
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule
